// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core: bus width, memory ops, LSU states.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} access_size_t;

  function automatic logic is_store(mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic access_size_t access_size(mem_op_t op);
    case (op)
      LB, LBU, SB: return SZ_B;
      LH, LHU, SH: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] ofs);
    case (access_size(op))
      SZ_H:    return ofs[0];
      SZ_W:    return |ofs;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replicated store data out, extended load data in.
module lsu_align
  import tartaruga_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte      = rdata[{ofs, 3'b000} +: 8];
    rhalf      = rdata[{ofs[1], 4'b0000} +: 16];
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;

    case (access_size(op))
      SZ_B: begin
        be         = 4'b0001 << ofs;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be         = 4'b0011 << ofs;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    case (op)
      LB:      rdata_ext = {{24{rbyte[7]}}, rbyte};
      LBU:     rdata_ext = {24'd0, rbyte};
      LH:      rdata_ext = {{16{rhalf[15]}}, rhalf};
      LHU:     rdata_ext = {16'd0, rhalf};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: one outstanding req/gnt/rvalid access at a time.
//   state | meaning
//   IDLE  | ready for a new op from EX
//   REQ   | mem_req_o held until mem_gnt_i
//   WAIT  | load granted, waiting for mem_rvalid_i
//   DONE  | one-cycle writeback pulse
module lsu
  import tartaruga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  mem_op_t     mem_op_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o
);

  lsu_state_t state;
  bus32_t     addr_q;
  bus32_t     wdata_q;
  mem_op_t    op_q;
  logic       mis_q;
  bus32_t     wb_data_q;

  logic [3:0] be;
  bus32_t     wdata_lane;
  bus32_t     rdata_ext;

  lsu_align u_align (
    .op         (op_q),
    .ofs        (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata_i),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= LB;
      mis_q     <= 1'b0;
      wb_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          addr_q    <= addr_i;
          wdata_q   <= wdata_i;
          op_q      <= mem_op_i;
          mis_q     <= is_misaligned(mem_op_i, addr_i[1:0]);
          wb_data_q <= '0;
          state     <= is_misaligned(mem_op_i, addr_i[1:0]) ? DONE : REQ;
        end
        REQ:  if (mem_gnt_i) state <= is_store(op_q) ? DONE : WAIT;
        WAIT: if (mem_rvalid_i) begin
          wb_data_q <= rdata_ext;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are gated by REQ so they read as 0 whenever no request is live.
  assign req_ready_o  = (state == IDLE);
  assign mem_req_o    = (state == REQ);
  assign mem_addr_o   = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
  assign mem_we_o     = mem_req_o & is_store(op_q);
  assign mem_be_o     = mem_req_o ? be : 4'b0000;
  assign mem_wdata_o  = mem_we_o ? wdata_lane : '0;
  assign wb_valid_o   = (state == DONE);
  assign wb_data_o    = wb_valid_o ? wb_data_q : '0;
  assign misaligned_o = wb_valid_o & mis_q;

endmodule
